es_alu_sequencer: RTL and testbench

ES_ALU_SEQUENCER -- requirements
Module: es_alu_sequencer

---
 rtl/es_alu_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_es_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/es_alu_sequencer.sv
// ---------------------------------------------------------------------------
// es_alu_sequencer
//
// Runs one ALU operation on the two top expression-stack entries. It then
// drives the stack through pop, pop, push so that the two operands are
// replaced by the result.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   request an operation (sampled only while idle)
//   aluOp    in   [2:0] operation code, captured with start
//   tosRega  in   [WIDTH-1:0] top of stack (operand A)
//   tosRegb  in   [WIDTH-1:0] next on stack (operand B)
//   busy     out  high whenever an operation is in flight
//   done     out  one-cycle pulse together with the result push
//   result   out  [WIDTH-1:0] last result, held until the next one
//   zero     out  high when result == 0
//   ESAct    out  stack action enable
//   ESOp     out  [1:0] stack op: 00 push, 01 pop
//   pushSrc  out  [2:0] PUSH_SRC_ALU during the push, else 0
//
// Result = opB op opA, modulo 2^WIDTH.
//   000 add      001 sub (B-A)   010 and      011 or
//   100 xor      101 B<<A[3:0]   110 B>>A[3:0] 111 mul (low WIDTH bits)
//
// Multiply is a shift-add loop that stays in EXEC for WIDTH cycles. Every
// other op leaves EXEC after one cycle. All outputs are registers.
// ---------------------------------------------------------------------------
module es_alu_sequencer #(
    parameter int         WIDTH        = 16,
    parameter logic [2:0] PUSH_SRC_ALU = 3'd5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] tosRega,
    input  logic [WIDTH-1:0] tosRegb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ESAct,
    output logic [1:0]       ESOp,
    output logic [2:0]       pushSrc
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        POP_A,
        POP_B,
        PUSH
    } state_t;

    state_t           state_reg;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;

    // Shift-add multiplier working registers.
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             es_act_reg;
    logic [1:0]       es_op_reg;
    logic [2:0]       push_src_reg;

    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] mul_step;

    // Single-cycle ops, computed from the captured operands only.
    always_comb begin
        single_res = '0;
        case (op_reg)
            3'b000:  single_res = op_b_reg + op_a_reg;
            3'b001:  single_res = op_b_reg - op_a_reg;
            3'b010:  single_res = op_b_reg & op_a_reg;
            3'b011:  single_res = op_b_reg | op_a_reg;
            3'b100:  single_res = op_b_reg ^ op_a_reg;
            3'b101:  single_res = op_b_reg << op_a_reg[3:0];
            3'b110:  single_res = op_b_reg >> op_a_reg[3:0];
            default: single_res = '0;
        endcase
    end

    // Accumulator value after the current multiplier bit has been added.
    // On the last step this is already the final product.
    assign mul_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            es_act_reg   <= 1'b0;
            es_op_reg    <= 2'b00;
            push_src_reg <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg     <= aluOp;
                        op_a_reg   <= tosRega;
                        op_b_reg   <= tosRegb;
                        acc_reg    <= '0;
                        mcand_reg  <= tosRegb;
                        mplier_reg <= tosRega;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= EXEC;
                    end
                end

                EXEC: begin
                    if (op_reg == OP_MUL) begin
                        acc_reg    <= mul_step;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        cnt_reg    <= cnt_reg + CW'(1);
                        // Only the final product is published; partial
                        // sums stay internal.
                        if (cnt_reg == MUL_LAST) begin
                            result_reg <= mul_step;
                            zero_reg   <= (mul_step == '0);
                            es_act_reg <= 1'b1;
                            es_op_reg  <= 2'b01;
                            state_reg  <= POP_A;
                        end
                    end else begin
                        result_reg <= single_res;
                        zero_reg   <= (single_res == '0);
                        es_act_reg <= 1'b1;
                        es_op_reg  <= 2'b01;
                        state_reg  <= POP_A;
                    end
                end

                POP_A: begin
                    state_reg <= POP_B;
                end

                POP_B: begin
                    es_op_reg    <= 2'b00;
                    push_src_reg <= PUSH_SRC_ALU;
                    done_reg     <= 1'b1;
                    state_reg    <= PUSH;
                end

                PUSH: begin
                    // start seen here is dropped. It is accepted again
                    // on the next cycle, once the FSM is back in IDLE.
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    es_act_reg   <= 1'b0;
                    push_src_reg <= 3'd0;
                    state_reg    <= IDLE;
                end

                default: begin
                    busy_reg     <= 1'b0;
                    done_reg     <= 1'b0;
                    es_act_reg   <= 1'b0;
                    es_op_reg    <= 2'b00;
                    push_src_reg <= 3'd0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign result  = result_reg;
    assign zero    = zero_reg;
    assign ESAct   = es_act_reg;
    assign ESOp    = es_op_reg;
    assign pushSrc = push_src_reg;

endmodule

// File: tb/tb_es_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_es_alu_sequencer
//
// Directed vectors for es_alu_sequencer.
//
// The reference model is a transaction timeline. An accepted start opens a
// window of L cycles: L = 4 for most ops and L = 19 for multiply.
// - busy is high for the whole window.
// - The last three cycles of the window are pop, pop, push.
// - The push cycle also carries done.
// - The result is computed with plain arithmetic when the op is accepted.
//   It becomes visible three cycles before the window ends.
//
// A compare process checks every output on every falling edge.
// Literal checks on results and latencies pin the model itself.
// ---------------------------------------------------------------------------
module tb_es_alu_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   aluOp = 3'd0;
    logic [W-1:0] tosRega = '0;
    logic [W-1:0] tosRegb = '0;

    logic         busy, done, zero, ESAct;
    logic [1:0]   ESOp;
    logic [2:0]   pushSrc;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    es_alu_sequencer #(.WIDTH(W), .PUSH_SRC_ALU(3'd5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .aluOp   (aluOp),
        .tosRega (tosRega),
        .tosRegb (tosRegb),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .ESAct   (ESAct),
        .ESOp    (ESOp),
        .pushSrc (pushSrc)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;
    int cyc = 0;

    // ---------------- behavioural model ----------------
    int           m_t = 0;       // cycles since acceptance, 0 = idle
    int           m_len = 4;     // length of the current window
    logic [W-1:0] m_pend = '0;   // result of the accepted op
    logic [W-1:0] m_res = '0;    // result the DUT should show

    function automatic logic [W-1:0] calc(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [31:0] p;
        int sh;
        sh = int'(a[3:0]);
        p  = 32'(b) * 32'(a);
        case (op)
            3'd0:    return b + a;
            3'd1:    return b - a;
            3'd2:    return b & a;
            3'd3:    return b | a;
            3'd4:    return b ^ a;
            3'd5:    return b << sh;
            3'd6:    return b >> sh;
            default: return p[W-1:0];
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_t   <= 0;
            m_res <= '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t    <= 1;
                m_len  <= (aluOp == 3'd7) ? 19 : 4;
                m_pend <= calc(aluOp, tosRega, tosRegb);
            end
        end else begin
            m_t <= (m_t == m_len) ? 0 : m_t + 1;
            if (m_t == m_len - 3) m_res <= m_pend;
        end
    end

    logic       e_busy, e_done, e_act, e_zero;
    logic [1:0] e_op;
    logic [2:0] e_src;
    assign e_busy = (m_t != 0);
    assign e_done = (m_t != 0) && (m_t == m_len);
    assign e_act  = (m_t != 0) && (m_t >= m_len - 2);
    assign e_op   = (e_act && !e_done) ? 2'b01 : 2'b00;
    assign e_src  = e_done ? 3'd5 : 3'd0;
    assign e_zero = (m_res == '0);

    logic [24:0] act_vec, exp_vec;
    assign act_vec = {busy, done, ESAct, ESOp, pushSrc, zero, result};
    assign exp_vec = {e_busy, e_done, e_act, e_op, e_src, e_zero, m_res};

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp = n_cmp + 1;
            if (act_vec !== exp_vec) begin
                n_err = n_err + 1;
                $display("FAIL cycle_%0d outputs: got busy=%b done=%b act=%b op=%b src=%0d zero=%b res=%h, want busy=%b done=%b act=%b op=%b src=%0d zero=%b res=%h",
                         cyc, busy, done, ESAct, ESOp, pushSrc, zero, result,
                         e_busy, e_done, e_act, e_op, e_src, e_zero, m_res);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Issue one op and wait for done.
    // latency = the edge that samples done, counted from the start edge.
    task automatic run_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2:0] op,
                          input int exp_lat, input logic [W-1:0] exp_res,
                          input bit poke);
        int lat;
        logic [2:0] h1, h2;
        lat = 0;
        h1  = 3'b0;
        h2  = 3'b0;
        @(negedge clk);
        tosRega = a;
        tosRegb = b;
        aluOp   = op;
        start   = 1'b1;
        @(negedge clk);
        // Scramble the inputs after capture; the result must not change.
        start   = 1'b0;
        tosRega = ~a;
        tosRegb = b ^ 16'h5A5A;
        aluOp   = ~op;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i + 1;
                break;
            end
            h2 = h1;
            h1 = {ESAct, ESOp};
            if (poke) start = (i % 3 == 0);
        end
        start = 1'b0;
        if (lat == 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL %s_timeout: got no done within 40 cycles, want done", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({name, "_result"}, 32'(result), 32'(exp_res));
            check({name, "_zero"}, 32'(zero), 32'(exp_res == '0));
            check({name, "_stackseq"}, {23'd0, h2, h1, ESAct, ESOp},
                  {23'd0, 3'b101, 3'b101, 3'b100});
            check({name, "_pushsrc"}, 32'(pushSrc), 32'd5);
        end
        $display("op %s: a=%h b=%h aluOp=%0d -> result=%h zero=%b latency=%0d",
                 name, a, b, op, result, zero, lat);
    endtask

    initial begin
        int dcount;
        int last_d;
        int bad_gap;
        int bad_act;

        // Reset held 3 cycles with start low.
        @(posedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_result", 32'(result), 32'd0);
            check("reset_zero", 32'(zero), 32'd1);
            check("reset_esact", 32'(ESAct), 32'd0);
        end
        reset = 1'b0;
        $display("reset: busy=%b result=%h zero=%b", busy, result, zero);

        run_op("sub",     16'd3,     16'd10,    3'd1, 4,  16'd7,     1'b0);
        run_op("add_wrap",16'd1,     16'hFFFF,  3'd0, 4,  16'd0,     1'b0);
        run_op("shl4",    16'd4,     16'd1,     3'd5, 4,  16'd16,    1'b0);
        run_op("shl0",    16'h0010,  16'hABCD,  3'd5, 4,  16'hABCD,  1'b0);
        run_op("shr15",   16'h001F,  16'h8000,  3'd6, 4,  16'h0001,  1'b0);
        run_op("shr4",    16'd4,     16'h8000,  3'd6, 4,  16'h0800,  1'b1);
        run_op("or",      16'h00F0,  16'h0F00,  3'd3, 4,  16'h0FF0,  1'b0);
        run_op("xor",     16'hFFFF,  16'h1234,  3'd4, 4,  16'hEDCB,  1'b0);
        run_op("mul_zero",16'd0,     16'd1234,  3'd7, 19, 16'd0,     1'b0);
        run_op("mul_ffff",16'hFFFF,  16'hFFFF,  3'd7, 19, 16'h0001,  1'b0);
        run_op("mul_300", 16'd300,   16'd300,   3'd7, 19, 16'h5F90,  1'b1);

        // Reset during the 8th multiply cycle.
        @(negedge clk);
        tosRega = 16'd300;
        tosRegb = 16'd300;
        aluOp   = 3'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midmul_busy", 32'(busy), 32'd0);
        check("midmul_result", 32'(result), 32'd0);
        check("midmul_zero", 32'(zero), 32'd1);
        bad_act = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ESAct || done) bad_act++;
        end
        check("midmul_no_stack_ops", 32'(bad_act), 32'd0);
        $display("mid-multiply reset: busy=%b result=%h stray_cycles=%0d", busy, result, bad_act);

        // Back-to-back with start held high.
        @(negedge clk);
        tosRega = 16'hF0F0;
        tosRegb = 16'h3C3C;
        aluOp   = 3'd2;
        start   = 1'b1;
        dcount  = 0;
        last_d  = -1;
        bad_gap = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done) begin
                if (last_d >= 0 && i - last_d != 5) bad_gap++;
                last_d = i;
                dcount++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(dcount), 32'd6);
        check("b2b_gap", 32'(bad_gap), 32'd0);
        check("b2b_result", 32'(result), 32'h3030);
        $display("back-to-back: dones=%0d bad_gaps=%0d result=%h", dcount, bad_gap, result);
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
